// File: rtl/rsa_wrapper_pkg.sv
// Shared types and sizes for the RSA-256 UART wrapper.
// RSA_WRAPPER_FULL_OUTPUT_EN sends all 32 result bytes instead of 31.
package rsa_wrapper_pkg;

    typedef enum logic [2:0] {
        S_QUERY_RX,
        S_READ,
        S_CALC,
        S_QUERY_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        FLD_N,
        FLD_D,
        FLD_A
    } field_t;

    localparam int RSA_BYTES = 32;

`ifdef RSA_WRAPPER_FULL_OUTPUT_EN
    localparam int RSA_OUT_BYTES = 32;
`else
    localparam int RSA_OUT_BYTES = 31;
`endif

    // A repeats forever once the key has been loaded.
    function automatic field_t next_field(input field_t f);
        if (f == FLD_N) return FLD_D;
        return FLD_A;
    endfunction

endpackage

// File: rtl/avm_byte_port.sv
// Poll-then-transfer Avalon-MM sequencer for one byte direction.
// Computes the next bus register values; the owner holds the registers.
module avm_byte_port
    import rsa_wrapper_pkg::*;
#(
    parameter logic [4:0] DATA_ADDR   = 5'd0,
    parameter logic [4:0] STATUS_ADDR = 5'd8,
    parameter bit         IS_TX       = 1'b0
) (
    input  logic        query,
    input  logic        status_bit,
    input  logic        waitrequest,
    input  logic [4:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [7:0]  tx_byte,
    output logic        ready,
    output logic        done,
    output logic [4:0]  nxt_address,
    output logic        nxt_read,
    output logic        nxt_write,
    output logic [31:0] nxt_writedata
);

    logic accept;

    always_comb begin
        accept        = (read | write) & ~waitrequest;
        ready         = query & accept & status_bit;
        done          = ~query & accept;
        nxt_address   = address;
        nxt_read      = read;
        nxt_write     = write;
        nxt_writedata = writedata;
        if (query) begin
            nxt_address = STATUS_ADDR;
            nxt_read    = 1'b1;
            nxt_write   = 1'b0;
            if (ready) begin
                nxt_address = DATA_ADDR;
                if (IS_TX) begin
                    nxt_read      = 1'b0;
                    nxt_write     = 1'b1;
                    nxt_writedata = {24'd0, tx_byte};
                end
            end
        end else if (done) begin
            nxt_address = STATUS_ADDR;
            nxt_read    = 1'b1;
            nxt_write   = 1'b0;
        end
    end

endmodule

// File: rtl/rsa256_uart_wrapper.sv
// UART bus-master front end for the RSA-256 core: loads N, d, A, returns plaintext.
// RSA_WRAPPER_FULL_OUTPUT_EN transmits result[255:248] as an extra first byte.
module rsa256_uart_wrapper
    import rsa_wrapper_pkg::*;
#(
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8,
    parameter int         RRDY_BIT    = 7,
    parameter int         TRDY_BIT    = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);

    state_t       state;
    field_t       field;
    logic [5:0]   cnt;
    logic [255:0] out_sr;
    logic [7:0]   tx_byte;
    logic         unused_ok;

    logic         rx_ready, rx_done, tx_ready, tx_done;
    logic [4:0]   rx_addr, tx_addr;
    logic         rx_rd, rx_wr, tx_rd, tx_wr;
    logic [31:0]  rx_wd, tx_wd;

`ifdef RSA_WRAPPER_FULL_OUTPUT_EN
    assign tx_byte   = out_sr[255:248];
    assign unused_ok = ^avm_readdata[31:8];
`else
    assign tx_byte   = out_sr[247:240];
    assign unused_ok = ^{avm_readdata[31:8], out_sr[255:248]};
`endif

    avm_byte_port #(
        .DATA_ADDR   (RX_BASE),
        .STATUS_ADDR (STATUS_BASE),
        .IS_TX       (1'b0)
    ) u_rx (
        .query         (state == S_QUERY_RX),
        .status_bit    (avm_readdata[RRDY_BIT]),
        .waitrequest   (avm_waitrequest),
        .address       (avm_address),
        .read          (avm_read),
        .write         (avm_write),
        .writedata     (avm_writedata),
        .tx_byte       (tx_byte),
        .ready         (rx_ready),
        .done          (rx_done),
        .nxt_address   (rx_addr),
        .nxt_read      (rx_rd),
        .nxt_write     (rx_wr),
        .nxt_writedata (rx_wd)
    );

    avm_byte_port #(
        .DATA_ADDR   (TX_BASE),
        .STATUS_ADDR (STATUS_BASE),
        .IS_TX       (1'b1)
    ) u_tx (
        .query         (state == S_QUERY_TX),
        .status_bit    (avm_readdata[TRDY_BIT]),
        .waitrequest   (avm_waitrequest),
        .address       (avm_address),
        .read          (avm_read),
        .write         (avm_write),
        .writedata     (avm_writedata),
        .tx_byte       (tx_byte),
        .ready         (tx_ready),
        .done          (tx_done),
        .nxt_address   (tx_addr),
        .nxt_read      (tx_rd),
        .nxt_write     (tx_wr),
        .nxt_writedata (tx_wd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_QUERY_RX;
            field         <= FLD_N;
            cnt           <= 6'd0;
            out_sr        <= '0;
            avm_address   <= STATUS_BASE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'd0;
            o_core_start  <= 1'b0;
            o_core_n      <= '0;
            o_core_d      <= '0;
            o_core_a      <= '0;
        end else begin
            o_core_start <= 1'b0;
            unique case (state)
                S_QUERY_RX: begin
                    avm_address   <= rx_addr;
                    avm_read      <= rx_rd;
                    avm_write     <= rx_wr;
                    avm_writedata <= rx_wd;
                    if (rx_ready) state <= S_READ;
                end
                S_READ: begin
                    avm_address   <= rx_addr;
                    avm_read      <= rx_rd;
                    avm_write     <= rx_wr;
                    avm_writedata <= rx_wd;
                    if (rx_done) begin
                        cnt   <= cnt + 6'd1;
                        state <= S_QUERY_RX;
                        unique case (field)
                            FLD_N:   o_core_n <= {o_core_n[247:0], avm_readdata[7:0]};
                            FLD_D:   o_core_d <= {o_core_d[247:0], avm_readdata[7:0]};
                            default: o_core_a <= {o_core_a[247:0], avm_readdata[7:0]};
                        endcase
                        if (cnt == 6'(RSA_BYTES - 1)) begin
                            cnt   <= 6'd0;
                            field <= next_field(field);
                            if (field == FLD_A) begin
                                avm_read     <= 1'b0;
                                o_core_start <= 1'b1;
                                state        <= S_CALC;
                            end
                        end
                    end
                end
                S_CALC: begin
                    // A done pulse coincident with our own start is stale.
                    if (i_core_finished && !o_core_start) begin
                        out_sr      <= i_core_result;
                        cnt         <= 6'd0;
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_BASE;
                        state       <= S_QUERY_TX;
                    end
                end
                S_QUERY_TX: begin
                    avm_address   <= tx_addr;
                    avm_read      <= tx_rd;
                    avm_write     <= tx_wr;
                    avm_writedata <= tx_wd;
                    if (tx_ready) state <= S_WRITE;
                end
                S_WRITE: begin
                    avm_address   <= tx_addr;
                    avm_read      <= tx_rd;
                    avm_write     <= tx_wr;
                    avm_writedata <= tx_wd;
                    if (tx_done) begin
                        out_sr <= out_sr << 8;
                        cnt    <= cnt + 6'd1;
                        state  <= S_QUERY_TX;
                        if (cnt == 6'(RSA_OUT_BYTES - 1)) begin
                            cnt   <= 6'd0;
                            field <= FLD_A;
                            state <= S_QUERY_RX;
                        end
                    end
                end
                default: state <= S_QUERY_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// Directed bench: UART model, behavioural RSA core, hand-computed plaintexts.
// Expected TX length follows RSA_WRAPPER_FULL_OUTPUT_EN.
`timescale 1ns/1ps
module tb_rsa256_uart_wrapper;

`ifdef RSA_WRAPPER_FULL_OUTPUT_EN
    localparam int OUT_BYTES = 32;
`else
    localparam int OUT_BYTES = 31;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest = 1'b0;
    logic         core_start;
    logic [255:0] core_a, core_d, core_n;
    logic [255:0] core_result;
    logic         core_finished;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_mem [0:1023];
    logic [9:0] rx_wr_ptr = 10'd0;
    logic [9:0] rx_rd_ptr = 10'd0;
    logic [7:0] tx_log [0:1023];
    int tx_cnt = 0;
    int tx_base = 0;
    int stall_len = 0;
    int stall_base = 0;
    int stall_polls = 0;
    int status_reads = 0;
    int rx_reads = 0;
    int rx_early = 0;
    int both_hi = 0;
    int wd_hi = 0;
    int cyc = 0;
    int rx_acc_cyc = 0;
    int start_gap = 0;
    int start_count = 0;
    int timer = 0;
    bit spurious = 1'b0;
    logic fin_reg = 1'b0;
    logic [63:0] res_val = 64'd0;
    logic [255:0] seen_n = '0, seen_d = '0, seen_a = '0;
    logic rx_pending, rrdy;

    always #5 clk = ~clk;

    rsa256_uart_wrapper dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_core_start    (core_start),
        .o_core_a        (core_a),
        .o_core_d        (core_d),
        .o_core_n        (core_n),
        .i_core_result   (core_result),
        .i_core_finished (core_finished)
    );

    assign rx_pending = rx_wr_ptr != rx_rd_ptr;
    assign rrdy = rx_pending && ((stall_polls - stall_base) >= stall_len);
    assign avm_readdata = (avm_address == 5'd8) ? {24'd0, rrdy, 1'b1, 6'd0} :
                          (avm_address == 5'd0) ? {24'd0, rx_mem[rx_rd_ptr]} : 32'd0;
    assign core_result = {192'd0, res_val};
    assign core_finished = fin_reg | (spurious & core_start);

    function automatic logic [63:0] modpow(logic [63:0] b, logic [63:0] e, logic [63:0] m);
        logic [63:0] r = 64'd1;
        b = b % m;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    // UART side of the bus
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_read && avm_write) both_hi <= both_hi + 1;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address == 5'd8) begin
                status_reads <= status_reads + 1;
                if (rx_pending && !rrdy) stall_polls <= stall_polls + 1;
            end else if (avm_address == 5'd0) begin
                rx_reads   <= rx_reads + 1;
                rx_acc_cyc <= cyc;
                if (!rrdy) rx_early <= rx_early + 1;
                else rx_rd_ptr <= rx_rd_ptr + 10'd1;
            end
        end
        if (avm_write && !avm_waitrequest) begin
            tx_log[tx_cnt] <= avm_writedata[7:0];
            tx_cnt <= tx_cnt + 1;
            if (avm_writedata[31:8] != 24'd0) wd_hi <= wd_hi + 1;
        end
    end

    // Behavioural core
    always @(posedge clk) begin
        if (core_start) begin
            start_count <= start_count + 1;
            start_gap   <= cyc - rx_acc_cyc;
            seen_n      <= core_n;
            seen_d      <= core_d;
            seen_a      <= core_a;
            res_val     <= modpow(core_a[63:0], core_d[63:0], core_n[63:0]);
            timer       <= 6;
        end else if (timer > 0) begin
            timer <= timer - 1;
        end
        fin_reg <= (timer == 1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic push_field(input logic [255:0] v);
        for (int i = 0; i < 32; i++) begin
            rx_mem[rx_wr_ptr] = v[255 - 8 * i -: 8];
            rx_wr_ptr = rx_wr_ptr + 10'd1;
        end
    endtask

    task automatic wait_tx(output bit ok);
        for (int i = 0; i < 4000 && (tx_cnt - tx_base) < OUT_BYTES; i++)
            @(negedge clk);
        ok = (tx_cnt - tx_base) >= OUT_BYTES;
        repeat (6) @(negedge clk);
    endtask

    function automatic int nonzero_lead();
        int nz = 0;
        for (int i = 0; i < OUT_BYTES - 1; i++)
            if (tx_log[tx_base + i] !== 8'h00) nz++;
        return nz;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (avm_address !== 5'd8) begin
            errors++; $display("FAIL reset_address: got %0d want 8", avm_address);
        end
        checks++;
        if ({avm_read, avm_write, core_start} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {avm_read, avm_write, core_start});
        end
        checks++;
        if (avm_writedata !== 32'd0) begin
            errors++; $display("FAIL reset_writedata: got %h want 0", avm_writedata);
        end
        checks++;
        if ({core_n, core_d, core_a} !== 768'd0) begin
            errors++; $display("FAIL reset_core_inputs: n/d/a not zero");
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (!(avm_read === 1'b1 && avm_address === 5'd8)) begin
            errors++; $display("FAIL first_poll: got read=%b addr=%0d want 1/8", avm_read, avm_address);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int s0 = start_count;
        int r0 = rx_reads;
        spurious = 1'b1;
        tx_base = tx_cnt;
        push_field(256'd33);
        push_field(256'd7);
        push_field(256'd4);
        wait_tx(ok);
        spurious = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d bytes want %0d", tx_cnt - tx_base, OUT_BYTES); end
        checks++;
        if (start_count - s0 !== 1) begin errors++; $display("FAIL basic_starts: got %0d want 1", start_count - s0); end
        checks++;
        if (seen_n !== 256'd33 || seen_d !== 256'd7 || seen_a !== 256'd4) begin
            errors++; $display("FAIL basic_core_in: got n=%0d d=%0d a=%0d want 33 7 4", seen_n[31:0], seen_d[31:0], seen_a[31:0]);
        end
        checks++;
        if (start_gap !== 1) begin errors++; $display("FAIL start_latency: got %0d want 1", start_gap); end
        checks++;
        if (rx_reads - r0 !== 96) begin errors++; $display("FAIL basic_rx_reads: got %0d want 96", rx_reads - r0); end
        checks++;
        if (tx_cnt - tx_base !== OUT_BYTES) begin errors++; $display("FAIL basic_tx_len: got %0d want %0d", tx_cnt - tx_base, OUT_BYTES); end
        checks++;
        if (nonzero_lead() !== 0) begin errors++; $display("FAIL basic_tx_zeros: got %0d nonzero want 0", nonzero_lead()); end
        checks++;
        if (tx_log[tx_base + OUT_BYTES - 1] !== 8'h10) begin
            errors++; $display("FAIL basic_tx_last: got %h want 10", tx_log[tx_base + OUT_BYTES - 1]);
        end
    endtask

    task automatic test_key_reuse();
        bit ok;
        int s0 = start_count;
        int r0 = rx_reads;
        tx_base = tx_cnt;
        push_field(256'd2);
        wait_tx(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reuse_timeout: got %0d bytes want %0d", tx_cnt - tx_base, OUT_BYTES); end
        checks++;
        if (rx_reads - r0 !== 32 || start_count - s0 !== 1) begin
            errors++; $display("FAIL reuse_reads: got rx=%0d starts=%0d want 32 1", rx_reads - r0, start_count - s0);
        end
        checks++;
        if (seen_n !== 256'd33 || seen_d !== 256'd7 || seen_a !== 256'd2) begin
            errors++; $display("FAIL reuse_core_in: got n=%0d d=%0d a=%0d want 33 7 2", seen_n[31:0], seen_d[31:0], seen_a[31:0]);
        end
        checks++;
        if (nonzero_lead() !== 0 || tx_log[tx_base + OUT_BYTES - 1] !== 8'h1D) begin
            errors++; $display("FAIL reuse_tx: got last=%h lead_nz=%0d want 1d 0", tx_log[tx_base + OUT_BYTES - 1], nonzero_lead());
        end
    endtask

    task automatic test_rx_not_ready();
        bit ok;
        int s0 = status_reads;
        int r0 = rx_reads;
        int e0 = rx_early;
        int i;
        stall_base = stall_polls;
        stall_len = 5;
        tx_base = tx_cnt;
        push_field(256'd4);
        for (i = 0; i < 200 && rx_reads == r0; i++) @(negedge clk);
        checks++;
        if (stall_polls - stall_base !== 5) begin errors++; $display("FAIL notready_polls: got %0d want 5", stall_polls - stall_base); end
        checks++;
        if (status_reads - s0 !== 6 || rx_reads - r0 !== 1) begin
            errors++; $display("FAIL notready_seq: got status=%0d rx=%0d want 6 1", status_reads - s0, rx_reads - r0);
        end
        checks++;
        if (rx_early !== e0) begin errors++; $display("FAIL notready_early_rx: got %0d want %0d", rx_early, e0); end
        stall_len = 0;
        wait_tx(ok);
        checks++;
        if (!ok || tx_log[tx_base + OUT_BYTES - 1] !== 8'h10) begin
            errors++; $display("FAIL notready_tx: got last=%h want 10", tx_log[tx_base + OUT_BYTES - 1]);
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        int rb = rx_reads;
        int r0;
        int held;
        int i;
        tx_base = tx_cnt;
        push_field(256'd2);
        for (i = 0; i < 200 && !(avm_read && avm_address == 5'd0); i++) @(negedge clk);
        r0 = rx_reads;
        avm_waitrequest = 1'b1;
        held = 1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (avm_read && avm_address == 5'd0) held++;
        end
        checks++;
        if (rx_reads !== r0) begin errors++; $display("FAIL wait_no_capture: got %0d reads want 0", rx_reads - r0); end
        avm_waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (held !== 4) begin errors++; $display("FAIL wait_held: got %0d cycles want 4", held); end
        checks++;
        if (rx_reads - r0 !== 1) begin errors++; $display("FAIL wait_capture: got %0d want 1", rx_reads - r0); end
        wait_tx(ok);
        checks++;
        if (!ok || rx_reads - rb !== 32 || seen_a !== 256'd2 || tx_log[tx_base + OUT_BYTES - 1] !== 8'h1D) begin
            errors++; $display("FAIL wait_result: got rx=%0d a=%0d last=%h want 32 2 1d", rx_reads - rb, seen_a[31:0], tx_log[tx_base + OUT_BYTES - 1]);
        end
    endtask

    task automatic test_reset_mid_output();
        bit ok;
        int r0;
        int i;
        tx_base = tx_cnt;
        push_field(256'd4);
        for (i = 0; i < 3000 && !((tx_cnt - tx_base) == 9 && avm_write); i++) @(negedge clk);
        checks++;
        if (!((tx_cnt - tx_base) == 9 && avm_write)) begin
            errors++; $display("FAIL midtx_reach: got %0d bytes want 9 and write", tx_cnt - tx_base);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (avm_write !== 1'b0 || avm_read !== 1'b0 || avm_address !== 5'd8) begin
            errors++; $display("FAIL midtx_reset: got w=%b r=%b addr=%0d want 0 0 8", avm_write, avm_read, avm_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rx_reads;
        tx_base = tx_cnt;
        push_field(256'd35);
        push_field(256'd5);
        push_field(256'd2);
        wait_tx(ok);
        checks++;
        if (!ok || rx_reads - r0 !== 96) begin errors++; $display("FAIL fresh_reads: got %0d want 96", rx_reads - r0); end
        checks++;
        if (seen_n !== 256'd35 || seen_d !== 256'd5 || seen_a !== 256'd2) begin
            errors++; $display("FAIL fresh_core_in: got n=%0d d=%0d a=%0d want 35 5 2", seen_n[31:0], seen_d[31:0], seen_a[31:0]);
        end
        checks++;
        if (nonzero_lead() !== 0 || tx_log[tx_base + OUT_BYTES - 1] !== 8'h20) begin
            errors++; $display("FAIL fresh_tx: got last=%h lead_nz=%0d want 20 0", tx_log[tx_base + OUT_BYTES - 1], nonzero_lead());
        end
    endtask

    task automatic test_bus_rules();
        checks++;
        if (both_hi !== 0) begin errors++; $display("FAIL read_write_overlap: got %0d want 0", both_hi); end
        checks++;
        if (wd_hi !== 0) begin errors++; $display("FAIL writedata_upper: got %0d want 0", wd_hi); end
        checks++;
        if (rx_early !== 0) begin errors++; $display("FAIL rx_without_data: got %0d want 0", rx_early); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_key_reuse();
        test_rx_not_ready();
        test_wait_states();
        test_reset_mid_output();
        test_bus_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
